// File: rtl/wb_release_unit.sv
// Writeback release unit: reads a victim line beat-by-beat from the data
// array and streams it out on the C channel as ReleaseData (voluntary) or
// ProbeAckData (probe response), then waits for ReleaseAck on voluntary lines.
module wb_release_unit #(
    parameter int BEATS = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [19:0] io_req_bits_tag,
    input  logic [5:0]  io_req_bits_idx,
    input  logic [2:0]  io_req_bits_param,
    input  logic [7:0]  io_req_bits_way_en,
    input  logic        io_req_bits_voluntary,

    output logic        io_data_req_valid,
    input  logic        io_data_req_ready,
    output logic [7:0]  io_data_req_bits_way_en,
    output logic [11:0] io_data_req_bits_addr,
    input  logic [63:0] io_data_resp,

    output logic        io_release_valid,
    input  logic        io_release_ready,
    output logic [2:0]  io_release_bits_opcode,
    output logic [2:0]  io_release_bits_param,
    output logic [31:0] io_release_bits_address,
    output logic [63:0] io_release_bits_data,

    input  logic        io_release_ack,

    output logic        io_busy,
    output logic [5:0]  io_busy_idx
);

    localparam logic [2:0] LAST_BEAT        = 3'(BEATS - 1);
    localparam logic [2:0] OP_RELEASE_DATA  = 3'd7;
    localparam logic [2:0] OP_PROBE_ACK_DAT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RESP,
        SEND,
        ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [19:0] tag_q;
    logic [5:0]  idx_q;
    logic [2:0]  param_q;
    logic [7:0]  way_en_q;
    logic        voluntary_q;
    logic [2:0]  beat_q;
    logic [63:0] beat_data_q;

    // State register; reset abandons any line in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one read, one response capture, one send per beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (io_req_valid)      state_nxt = READ;
            READ: if (io_data_req_ready) state_nxt = RESP;
            RESP:                        state_nxt = SEND;
            SEND: begin
                if (io_release_ready) begin
                    if (beat_q != LAST_BEAT) state_nxt = READ;
                    else if (voluntary_q)    state_nxt = ACK;
                    else                     state_nxt = IDLE;
                end
            end
            ACK:  if (io_release_ack)    state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Request capture, beat counter and beat data register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q       <= '0;
            idx_q       <= '0;
            param_q     <= '0;
            way_en_q    <= '0;
            voluntary_q <= 1'b0;
            beat_q      <= '0;
            beat_data_q <= '0;
        end else begin
            if (state == IDLE && io_req_valid) begin
                tag_q       <= io_req_bits_tag;
                idx_q       <= io_req_bits_idx;
                param_q     <= io_req_bits_param;
                way_en_q    <= io_req_bits_way_en;
                voluntary_q <= io_req_bits_voluntary;
                beat_q      <= '0;
            end
            if (state == RESP) begin
                beat_data_q <= io_data_resp;
            end
            // The counter holds at the last beat, so it never wraps within a line.
            if (state == SEND && io_release_ready && beat_q != LAST_BEAT) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Outputs decoded from state and captured request fields.
    always_comb begin
        io_req_ready            = (state == IDLE);
        io_busy                 = (state != IDLE);
        io_busy_idx             = idx_q;

        io_data_req_valid       = (state == READ);
        io_data_req_bits_way_en = way_en_q;
        io_data_req_bits_addr   = {idx_q, beat_q, 3'b000};

        io_release_valid        = (state == SEND);
        io_release_bits_opcode  = voluntary_q ? OP_RELEASE_DATA : OP_PROBE_ACK_DAT;
        io_release_bits_param   = param_q;
        io_release_bits_address = {tag_q, idx_q, 6'b000000};
        io_release_bits_data    = beat_data_q;
    end

endmodule

// File: tb/tb_wb_release_unit.sv
// Directed bench for wb_release_unit: a table of line requests, each run as a
// full writeback with a per-record back-pressure/reset scenario.
module tb_wb_release_unit;

    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [19:0] io_req_bits_tag = '0;
    logic [5:0]  io_req_bits_idx = '0;
    logic [2:0]  io_req_bits_param = '0;
    logic [7:0]  io_req_bits_way_en = '0;
    logic        io_req_bits_voluntary = 1'b0;
    logic        io_data_req_valid;
    logic        io_data_req_ready = 1'b1;
    logic [7:0]  io_data_req_bits_way_en;
    logic [11:0] io_data_req_bits_addr;
    logic [63:0] io_data_resp = GARBAGE;
    logic        io_release_valid;
    logic        io_release_ready = 1'b1;
    logic [2:0]  io_release_bits_opcode;
    logic [2:0]  io_release_bits_param;
    logic [31:0] io_release_bits_address;
    logic [63:0] io_release_bits_data;
    logic        io_release_ack = 1'b0;
    logic        io_busy;
    logic [5:0]  io_busy_idx;

    int checks = 0;
    int errors = 0;

    wb_release_unit #(.BEATS(8)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_req_valid            (io_req_valid),
        .io_req_ready            (io_req_ready),
        .io_req_bits_tag         (io_req_bits_tag),
        .io_req_bits_idx         (io_req_bits_idx),
        .io_req_bits_param       (io_req_bits_param),
        .io_req_bits_way_en      (io_req_bits_way_en),
        .io_req_bits_voluntary   (io_req_bits_voluntary),
        .io_data_req_valid       (io_data_req_valid),
        .io_data_req_ready       (io_data_req_ready),
        .io_data_req_bits_way_en (io_data_req_bits_way_en),
        .io_data_req_bits_addr   (io_data_req_bits_addr),
        .io_data_resp            (io_data_resp),
        .io_release_valid        (io_release_valid),
        .io_release_ready        (io_release_ready),
        .io_release_bits_opcode  (io_release_bits_opcode),
        .io_release_bits_param   (io_release_bits_param),
        .io_release_bits_address (io_release_bits_address),
        .io_release_bits_data    (io_release_bits_data),
        .io_release_ack          (io_release_ack),
        .io_busy                 (io_busy),
        .io_busy_idx             (io_busy_idx)
    );

    always #5 clock = ~clock;

    // mode: 0 all ready, 1 release stall at beat 3, 2 data_req_ready toggling,
    //       3 async reset during beat 5
    typedef struct {
        logic [19:0] tag;
        logic [5:0]  idx;
        logic [2:0]  param;
        logic [7:0]  way;
        logic        vol;
        int          mode;
        logic        ack_during;
        logic        hold;
        logic [63:0] salt;
        logic [2:0]  exp_op;
        logic [31:0] exp_address;
        logic [11:0] exp_rd0;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v);
        io_req_bits_tag       = v.tag;
        io_req_bits_idx       = v.idx;
        io_req_bits_param     = v.param;
        io_req_bits_way_en    = v.way;
        io_req_bits_voluntary = v.vol;
        io_req_valid          = 1'b1;
    endtask

    // Starts and ends on a negedge with the unit idle.
    task automatic run_line(input vec_t v, input vec_t nxt);
        int unsigned beat, rd, cyc, stall_left;
        bit          pend, done, aborted, rd_fire, rl_fire;
        logic [2:0]  pend_beat;

        drive_req(v);
        io_release_ack    = 1'b0;
        io_data_req_ready = 1'b1;
        io_release_ready  = 1'b1;
        check("req_ready_idle", 64'(io_req_ready), 64'd1);
        @(negedge clock);
        if (v.hold) drive_req(nxt);
        else        io_req_valid = 1'b0;
        io_release_ack = v.ack_during;

        beat = 0; rd = 0; cyc = 0; stall_left = 5;
        pend = 0; pend_beat = '0; done = 0; aborted = 0;
        while (!done && cyc < 200) begin
            check("busy_in_line", 64'(io_busy), 64'd1);
            check("req_ready_busy", 64'(io_req_ready), 64'd0);
            check("busy_idx", 64'(io_busy_idx), 64'(v.idx));
            check("valid_exclusive", 64'(io_data_req_valid & io_release_valid), 64'd0);

            io_data_resp = pend ? (v.salt | 64'(pend_beat)) : GARBAGE;
            pend = 0;

            if (v.mode == 1) begin
                if (io_release_valid && beat == 3 && stall_left > 0) begin
                    io_release_ready = 1'b0;
                    stall_left--;
                end else begin
                    io_release_ready = 1'b1;
                end
            end else if (v.mode == 2) begin
                io_data_req_ready = ~io_data_req_ready;
            end

            rd_fire = io_data_req_valid && io_data_req_ready;
            rl_fire = io_release_valid && io_release_ready;

            if (io_data_req_valid) begin
                check("rd_way_en", 64'(io_data_req_bits_way_en), 64'(v.way));
                check("rd_addr", 64'(io_data_req_bits_addr), 64'(v.exp_rd0 + 12'(8 * rd)));
            end
            if (rd_fire) begin
                pend = 1;
                pend_beat = 3'(rd);
                rd++;
            end

            if (io_release_valid) begin
                if (v.mode == 3 && beat == 5) begin
                    #2 reset = 1'b1;
                    #1;
                    check("rst_req_ready", 64'(io_req_ready), 64'd1);
                    check("rst_data_req_valid", 64'(io_data_req_valid), 64'd0);
                    check("rst_release_valid", 64'(io_release_valid), 64'd0);
                    check("rst_busy", 64'(io_busy), 64'd0);
                    check("rst_busy_idx", 64'(io_busy_idx), 64'd0);
                    check("rst_release_data", io_release_bits_data, 64'd0);
                    check("rst_release_address", 64'(io_release_bits_address), 64'd0);
                    check("rst_release_param", 64'(io_release_bits_param), 64'd0);
                    check("rst_rd_addr", 64'(io_data_req_bits_addr), 64'd0);
                    @(negedge clock);
                    reset = 1'b0;
                    done = 1;
                    aborted = 1;
                end else begin
                    check("rel_opcode", 64'(io_release_bits_opcode), 64'(v.exp_op));
                    check("rel_param", 64'(io_release_bits_param), 64'(v.param));
                    check("rel_address", 64'(io_release_bits_address), 64'(v.exp_address));
                    check("rel_data", io_release_bits_data, v.salt | 64'(beat));
                    check("reads_before_release", 64'(rd), 64'(beat + 1));
                end
            end

            if (rl_fire && !aborted) begin
                if (beat == 7) begin
                    done = 1;
                    if (v.mode == 0) check("line_cycles", 64'(cyc), 64'd23);
                    if (v.mode == 1) check("line_cycles_stall", 64'(cyc), 64'd28);
                end
                beat++;
            end

            if (!done) begin
                @(negedge clock);
                cyc++;
            end
        end

        io_data_req_ready = 1'b1;
        io_release_ready  = 1'b1;
        io_data_resp      = GARBAGE;

        if (!done) begin
            check("line_timeout", 64'(beat), 64'd8);
            io_release_ack = 1'b0;
            io_req_valid   = 1'b0;
            return;
        end
        if (aborted) begin
            io_release_ack = 1'b0;
            return;
        end

        @(negedge clock);
        if (v.vol) begin
            for (int k = 0; k < 4; k++) begin
                check("ack_wait_busy", 64'(io_busy), 64'd1);
                check("ack_wait_req_ready", 64'(io_req_ready), 64'd0);
                check("ack_wait_no_valid", 64'(io_release_valid | io_data_req_valid), 64'd0);
                @(negedge clock);
            end
            io_release_ack = 1'b1;
            @(negedge clock);
            io_release_ack = 1'b0;
            check("ack_done_busy", 64'(io_busy), 64'd0);
            check("ack_done_req_ready", 64'(io_req_ready), 64'd1);
        end else begin
            io_release_ack = 1'b1;
            check("probe_done_busy", 64'(io_busy), 64'd0);
            check("probe_done_req_ready", 64'(io_req_ready), 64'd1);
            @(negedge clock);
            io_release_ack = 1'b0;
            check("stray_ack_idle", 64'(io_busy), 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{20'h12345, 6'h2A, 3'd1, 8'h04, 1'b1, 0, 1'b0, 1'b0,
                    64'h0, 3'd7, 32'h12345A80, 12'hA80};
        vecs[1] = '{20'h12345, 6'h2A, 3'd1, 8'h04, 1'b0, 0, 1'b1, 1'b0,
                    64'hFACE_0000_0000_0000, 3'd5, 32'h12345A80, 12'hA80};
        vecs[2] = '{20'hABCDE, 6'h15, 3'd2, 8'h80, 1'b1, 1, 1'b0, 1'b0,
                    64'h5555_0000_0000_0000, 3'd7, 32'hABCDE540, 12'h540};
        vecs[3] = '{20'h12345, 6'h2A, 3'd0, 8'h01, 1'b0, 2, 1'b0, 1'b0,
                    64'h0123_4567_89AB_CDE0, 3'd5, 32'h12345A80, 12'hA80};
        vecs[4] = '{20'hFFFFF, 6'h3F, 3'd7, 8'h40, 1'b1, 3, 1'b0, 1'b0,
                    64'hAAAA_0000_0000_0000, 3'd7, 32'hFFFFFFC0, 12'hFC0};
        vecs[5] = '{20'h00001, 6'h01, 3'd3, 8'h02, 1'b1, 0, 1'b0, 1'b0,
                    64'h1000, 3'd7, 32'h00001040, 12'h040};
        vecs[6] = '{20'h0F0F0, 6'h10, 3'd4, 8'h08, 1'b1, 0, 1'b0, 1'b1,
                    64'h6600, 3'd7, 32'h0F0F0400, 12'h400};
        vecs[7] = '{20'h55555, 6'h07, 3'd6, 8'h10, 1'b0, 0, 1'b0, 1'b0,
                    64'h7700, 3'd5, 32'h555551C0, 12'h1C0};

        #1 reset = 1'b1;
        #1;
        check("reset_req_ready", 64'(io_req_ready), 64'd1);
        check("reset_data_req_valid", 64'(io_data_req_valid), 64'd0);
        check("reset_release_valid", 64'(io_release_valid), 64'd0);
        check("reset_busy", 64'(io_busy), 64'd0);
        check("reset_busy_idx", 64'(io_busy_idx), 64'd0);
        check("reset_release_data", io_release_bits_data, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_line(vecs[i], vecs[(i + 1) % 8]);
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_release_unit.md
WB_RELEASE_UNIT -- requirements
Module: wb_release_unit

Interface
REQ-001 The block SHALL have one parameter: BEATS, default 8, meaning 64-bit beats per 64-byte line (only 8 supported).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clock and reset.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 io_req_valid / io_req_ready  input / output  1 / 1  writeback request handshake.
REQ-006 io_req_bits_tag / _idx / _param / _way_en  input  20 / 6 / 3 / 8  line tag, set index, shrink param, one-hot victim way.
REQ-007 io_req_bits_voluntary  input  1  1 = voluntary release, 0 = probe response.
REQ-008 io_data_req_valid / io_data_req_ready  output / input  1 / 1  data-array read handshake.
REQ-009 io_data_req_bits_way_en / io_data_req_bits_addr  output  8 / 12  read way; addr = {idx, beat[2:0], 3'b000}.
REQ-010 io_data_resp  input  64  read data, valid exactly 1 cycle after a data-request fire.
REQ-011 io_release_valid / io_release_ready  output / input  1 / 1  C-channel beat handshake.
REQ-012 io_release_bits_opcode / _param / _address / _data  output  3 / 3 / 32 / 64  C-channel beat fields.
REQ-013 io_release_ack  input  1  single-cycle ReleaseAck pulse.
REQ-014 io_busy / io_busy_idx  output  1 / 6  unit occupied; index being written back.

Function
REQ-015 States SHALL be IDLE, READ, RESP, SEND, ACK; encoding free.
REQ-016 io_req_ready SHALL be 1 only in IDLE; on req fire, all req fields SHALL be captured, beat counter cleared, state -> READ.
REQ-017 READ: io_data_req_valid=1 with captured way_en and addr for current beat; on fire -> RESP.
REQ-018 RESP: io_data_resp SHALL be captured into a 64-bit beat register; -> SEND next cycle.
REQ-019 SEND: io_release_valid=1, data from beat register, held stable until io_release_ready.
REQ-020 On release fire with beat < 7: beat += 1, -> READ; with beat = 7: voluntary -> ACK, else -> IDLE.
REQ-021 ACK: wait for io_release_ack=1, then -> IDLE; io_release_ack outside ACK SHALL be ignored.
REQ-022 opcode SHALL be 3'd7 (ReleaseData) if voluntary, else 3'd5 (ProbeAckData); param = captured param.
REQ-023 address SHALL be {tag, idx, 6'b0} for every beat (line-aligned, constant across beats).
REQ-024 io_busy SHALL be 1 in every state except IDLE; io_busy_idx SHALL equal captured idx.
REQ-025 A line SHALL take minimum 3 cycles per beat (24 cycles) plus ACK wait; no overlap between lines.
REQ-026 Beat counter SHALL be 3 bits and SHALL never wrap within a line.
REQ-027 io_data_req_valid and io_release_valid SHALL never be 1 simultaneously.
REQ-028 Back-pressure (data_req_ready or release_ready low) SHALL stall in place without dropping or repeating beats.

Reset
REQ-029 Reset assertion SHALL force IDLE immediately, regardless of clock, abandoning any in-flight line.
REQ-030 Reset values: io_req_ready=1, io_data_req_valid=0, io_release_valid=0, io_busy=0, all captured fields and beat register 0.

Verification
REQ-031 Voluntary req tag=0x12345, idx=0x2A, param=1, way_en=0x04, all readies 1, data_resp=beat index -> 8 beats opcode 7, address 0x12345A80, data 0..7, ACK waits until ack pulse, then IDLE.
REQ-032 Probe req (voluntary=0) same fields -> opcode 5, returns to IDLE after beat 7 without ack; stray ack ignored.
REQ-033 release_ready low 5 cycles during beat 3 -> beat 3 data/address held stable, no data read issued, beats 4-7 follow in order.
REQ-034 data_req_ready toggling each cycle -> addr sequence 0xA80,0xA88,...,0xAB8; no duplicates.
REQ-035 Reset asserted mid-beat 5 -> outputs take reset values asynchronously; next req restarts at beat 0.
REQ-036 req_valid held high while busy -> req_ready stays 0 until IDLE; second request accepted exactly on IDLE cycle.
